// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch-to-decode output stage handshake
interface fetch_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_instr,
        output out_pc,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_instr,
        input  out_pc,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with stall, redirect, halt and accept count
module fetch_ctrl #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter bit HALT_ON_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              halted,
    output logic [15:0]       fetch_count,
    fetch_ctrl_if.master      dec
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              load;
    logic              zero_word;
    logic              accept;

    assign imem_addr = pc;

    // The output register may refill when empty or when decode drains it this cycle.
    assign load      = !dec.out_valid || dec.out_ready;
    assign zero_word = HALT_ON_ZERO && (imem_rdata == '0);
    assign accept    = dec.out_valid && dec.out_ready && !br_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pc            <= '0;
            dec.out_instr <= '0;
            dec.out_pc    <= '0;
            dec.out_valid <= 1'b0;
            halted        <= 1'b0;
            fetch_count   <= '0;
        end else begin
            // A word flushed by a same-cycle redirect never reaches decode, so it is not counted.
            if (accept && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (br_taken) begin
                        pc    <= br_target;
                        state <= S_RUN;
                    end else if (start) begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (br_taken) begin
                        pc            <= br_target;
                        dec.out_valid <= 1'b0;
                    end else if (load) begin
                        if (zero_word) begin
                            dec.out_valid <= 1'b0;
                            halted        <= 1'b1;
                            state         <= S_HALT;
                        end else begin
                            dec.out_instr <= imem_rdata;
                            dec.out_pc    <= pc;
                            dec.out_valid <= 1'b1;
                            pc            <= pc + ADDR_W'(1);
                        end
                    end
                end

                S_HALT: begin
                    // PC stays on the zero word until software redirects.
                    if (br_taken) begin
                        pc     <= br_target;
                        halted <= 1'b0;
                        state  <= S_RUN;
                    end
                end

                default: begin
                    state         <= S_IDLE;
                    dec.out_valid <= 1'b0;
                    halted        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT a halts on a zero word, DUT b runs through everything
    logic        reset_a, start_a, br_a, halted_a;
    logic [4:0]  target_a, addr_a;
    logic [31:0] rdata_a;
    logic [15:0] count_a;
    logic [31:0] mem_a [32];

    logic        reset_b, start_b, br_b, halted_b;
    logic [4:0]  target_b, addr_b;
    logic [31:0] rdata_b;
    logic [15:0] count_b;
    logic [31:0] mem_b [32];

    fetch_ctrl_if #(.ADDR_W(5), .DATA_W(32)) if_a ();
    fetch_ctrl_if #(.ADDR_W(5), .DATA_W(32)) if_b ();

    assign rdata_a = mem_a[addr_a];
    assign rdata_b = mem_b[addr_b];

    fetch_ctrl #(.ADDR_W(5), .DATA_W(32), .HALT_ON_ZERO(1'b1)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a),
        .imem_addr(addr_a), .imem_rdata(rdata_a),
        .br_taken(br_a), .br_target(target_a),
        .halted(halted_a), .fetch_count(count_a), .dec(if_a)
    );

    fetch_ctrl #(.ADDR_W(5), .DATA_W(32), .HALT_ON_ZERO(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b),
        .imem_addr(addr_b), .imem_rdata(rdata_b),
        .br_taken(br_b), .br_target(target_b),
        .halted(halted_b), .fetch_count(count_b), .dec(if_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out_a(input string tag, input logic v, input logic [31:0] instr, input logic [4:0] pc);
        check({tag, ".valid"}, {31'd0, if_a.out_valid}, {31'd0, v});
        if (v) begin
            check({tag, ".instr"}, if_a.out_instr, instr);
            check({tag, ".pc"}, {27'd0, if_a.out_pc}, {27'd0, pc});
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 32'h300 + i;
            mem_b[i] = 32'h1000 + i;
        end
        mem_a[0] = 32'h200; mem_a[1] = 32'h201; mem_a[2] = 32'h204;
        mem_a[3] = 32'h108; mem_a[4] = 32'h0;

        reset_a = 1'b1; start_a = 1'b0; br_a = 1'b0; target_a = '0; if_a.out_ready = 1'b1;
        reset_b = 1'b1; start_b = 1'b0; br_b = 1'b0; target_b = '0; if_b.out_ready = 1'b1;

        // reset state
        step();
        step();
        check("rst.valid", {31'd0, if_a.out_valid}, 32'd0);
        check("rst.halted", {31'd0, halted_a}, 32'd0);
        check("rst.count", {16'd0, count_a}, 32'd0);
        check("rst.addr", {27'd0, addr_a}, 32'd0);
        check("rst.instr", if_a.out_instr, 32'd0);
        check("rst.pc", {27'd0, if_a.out_pc}, 32'd0);

        // start: first word two edges later, then stream until the zero word
        reset_a = 1'b0; start_a = 1'b1;
        step();
        start_a = 1'b0;
        check_out_a("start.e1", 1'b0, 32'h0, 5'd0);
        step(); check_out_a("seq0", 1'b1, 32'h200, 5'd0);
        step(); check_out_a("seq1", 1'b1, 32'h201, 5'd1);
        check("seq1.count", {16'd0, count_a}, 32'd1);
        step(); check_out_a("seq2", 1'b1, 32'h204, 5'd2);
        step(); check_out_a("seq3", 1'b1, 32'h108, 5'd3);
        check("seq3.count", {16'd0, count_a}, 32'd3);
        step();
        check_out_a("halt", 1'b0, 32'h0, 5'd0);
        check("halt.halted", {31'd0, halted_a}, 32'd1);
        check("halt.addr", {27'd0, addr_a}, 32'd4);
        check("halt.count", {16'd0, count_a}, 32'd4);

        // start is ignored in HALT
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        check("halt.start_ign", {31'd0, halted_a}, 32'd1);
        check("halt.pc_hold", {27'd0, addr_a}, 32'd4);

        // redirect out of HALT to 0
        br_a = 1'b1; target_a = 5'd0;
        step();
        br_a = 1'b0; target_a = 5'd9;
        check("rehalt.halted", {31'd0, halted_a}, 32'd0);
        check_out_a("rehalt.bubble", 1'b0, 32'h0, 5'd0);
        step(); check_out_a("re0", 1'b1, 32'h200, 5'd0);
        step(); check_out_a("re1", 1'b1, 32'h201, 5'd1);
        check("re1.count", {16'd0, count_a}, 32'd5);

        // three cycles of backpressure on 0x201
        if_a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out_a("stall", 1'b1, 32'h201, 5'd1);
            check("stall.count", {16'd0, count_a}, 32'd5);
        end
        if_a.out_ready = 1'b1;
        step(); check_out_a("unstall", 1'b1, 32'h204, 5'd2);
        check("unstall.count", {16'd0, count_a}, 32'd6);

        // branch to 1 while 0x204 is being accepted: flushed, not counted
        br_a = 1'b1; target_a = 5'd1;
        step();
        br_a = 1'b0; target_a = 5'd7;
        check_out_a("br1.bubble", 1'b0, 32'h0, 5'd0);
        check("br1.count", {16'd0, count_a}, 32'd6);
        step(); check_out_a("br1.word", 1'b1, 32'h201, 5'd1);

        // branch to 2 in the cycle out_pc=1 with out_ready=1
        br_a = 1'b1; target_a = 5'd2;
        step();
        br_a = 1'b0; target_a = 5'd0;
        check_out_a("br2.bubble", 1'b0, 32'h0, 5'd0);
        step(); check_out_a("br2.word", 1'b1, 32'h204, 5'd2);
        check("br2.count", {16'd0, count_a}, 32'd6);
        step(); check_out_a("br2.next", 1'b1, 32'h108, 5'd3);
        check("br2.next.count", {16'd0, count_a}, 32'd7);

        // reset mid-stream
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        check("mid.valid", {31'd0, if_a.out_valid}, 32'd0);
        check("mid.count", {16'd0, count_a}, 32'd0);
        check("mid.addr", {27'd0, addr_a}, 32'd0);
        check("mid.instr", if_a.out_instr, 32'd0);
        step();
        check("idle.nofetch", {31'd0, if_a.out_valid}, 32'd0);
        check("idle.addr", {27'd0, addr_a}, 32'd0);

        // redirect from IDLE
        br_a = 1'b1; target_a = 5'd3;
        step();
        br_a = 1'b0;
        check_out_a("idlebr.bubble", 1'b0, 32'h0, 5'd0);
        step(); check_out_a("idlebr.word", 1'b1, 32'h108, 5'd3);

        // no-halt instance: wrap past 31, then saturate the counter
        reset_b = 1'b0; start_b = 1'b1;
        step();
        start_b = 1'b0;
        step();
        check("b.first", if_b.out_instr, 32'h1000);
        for (int i = 0; i < 40; i++) begin
            if (if_b.out_pc == 5'd31) break;
            step();
        end
        check("b.pc31", {27'd0, if_b.out_pc}, 32'd31);
        check("b.instr31", if_b.out_instr, 32'h101F);
        check("b.count31", {16'd0, count_b}, 32'd31);
        step();
        check("b.wrap.pc", {27'd0, if_b.out_pc}, 32'd0);
        check("b.wrap.instr", if_b.out_instr, 32'h1000);
        check("b.wrap.halted", {31'd0, halted_b}, 32'd0);
        check("b.wrap.count", {16'd0, count_b}, 32'd32);

        for (int i = 0; i < 65502; i++) step();
        check("b.near_sat", {16'd0, count_b}, 32'hFFFE);
        step();
        check("b.sat", {16'd0, count_b}, 32'hFFFF);
        for (int i = 0; i < 10; i++) step();
        check("b.sat_hold", {16'd0, count_b}, 32'hFFFF);
        check("b.sat.valid", {31'd0, if_b.out_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 32-entry, 32-bit instruction memory. Owns the program counter, drives the memory read address, and registers each fetched word into a valid/ready output stage for the decode logic. Supports stall by backpressure, branch redirect with flush, halt on an all-zero word, and a count of delivered instructions.

## Interface
- ADDR_W, 5, program counter and instruction memory address width; the memory holds 2^ADDR_W words
- DATA_W, 32, instruction width
- HALT_ON_ZERO, 1, when 1, a fetched word of 0 halts fetch
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  in IDLE, begins fetching at PC 0
- imem_addr  out  ADDR_W  read address to the instruction memory; always equals the PC register
- imem_rdata  in  DATA_W  instruction word, combinational read of imem_addr in the same cycle
- out_instr  out  DATA_W  registered instruction to decode
- out_pc  out  ADDR_W  address that out_instr was fetched from
- out_valid  out  1  out_instr/out_pc are valid
- out_ready  in  1  decode accepts the word this cycle
- br_taken  in  1  redirect request, one-cycle pulse
- br_target  in  ADDR_W  redirect address
- halted  out  1  high while in HALT
- fetch_count  out  16  number of instructions accepted by decode

## Operation
- States: IDLE, RUN, HALT. The state encoding is internal.
- Reset values: state IDLE, PC 0, imem_addr 0, out_instr 0, out_pc 0, out_valid 0, halted 0, fetch_count 0. Reset overrides every other input, including reset asserted in the middle of operation.
- IDLE:
  - start=1 moves to RUN; PC stays 0.
  - br_taken=1 moves to RUN and loads PC with br_target.
  - No fetch occurs while in IDLE.
- RUN, priority order highest first:
  1. br_taken=1: PC is loaded with br_target, out_valid is cleared (flush, even if out_ready=1 that cycle), and no capture occurs.
  2. Capture condition `load = !out_valid || out_ready`. When load=1 and imem_rdata != 0 (or HALT_ON_ZERO=0): out_instr <= imem_rdata, out_pc <= PC, out_valid <= 1, PC <= PC+1.
  3. When load=1, HALT_ON_ZERO=1 and imem_rdata == 0: out_valid <= 0, PC holds, and the state moves to HALT. The zero word is never presented to decode.
  4. When load=0 (stall): PC, out_instr, out_pc and out_valid all hold.
- PC arithmetic is modulo 2^ADDR_W; PC 31+1 wraps to 0 with no flag.
- HALT:
  - halted=1 and out_valid=0; PC holds at the address of the zero word.
  - br_taken=1 returns to RUN with PC = br_target and clears halted the next cycle.
  - start is ignored in HALT.
- fetch_count increments on every cycle where out_valid && out_ready && !br_taken. It saturates at 0xFFFF.
  - A word that is accepted in the same cycle as a br_taken is not counted, because the flush discards it.
- br_target is sampled only in the cycle where br_taken=1.

## Timing
- The address-to-data path is combinational. The first word after start appears with out_valid=1 exactly one cycle after the first RUN cycle, i.e. 2 edges after start is sampled.
- Steady-state throughput is 1 instruction per cycle while out_ready=1.
- Branch penalty: the first cycle after br_taken has out_valid=0. The word at br_target is valid on the following edge, giving a penalty of 1 bubble.
- Backpressure: while out_valid=1 and out_ready=0, all outputs are stable. No word is dropped or duplicated.
- Simultaneous out_ready=1 and br_taken=1: the branch wins. The presented word is flushed and not counted.
- The HALT decision is made in the same cycle the zero word is on imem_rdata. halted rises on the next edge.
- Because the memory reads combinationally, the memory loaded during reset is readable in the first RUN cycle.

## Test plan
- Reset, then start, with memory holding 0x200, 0x201, 0x204, 0x108, then 0, and out_ready=1 -> out_valid rises 2 edges after start; out_instr/out_pc sequence is 0x200/0, 0x201/1, 0x204/2, 0x108/3; then halted=1, PC=4, fetch_count=4.
- out_ready low for 3 cycles while out_instr=0x201 -> out_instr, out_pc and out_valid hold for 3 cycles; after release the next word is 0x204 with no gap; fetch_count counts 0x201 once.
- br_taken with br_target=2 in the cycle out_pc=1 and out_ready=1 -> next cycle out_valid=0; following cycle out_instr=0x204, out_pc=2; the flushed word is not counted.
- HALT_ON_ZERO=0 with all 32 words nonzero -> after out_pc=31 the next out_pc is 0 (wrap), with no halt.
- In HALT, pulse br_taken with br_target=0 -> halted falls, fetch restarts at 0x200/0. Asserting reset mid-stream -> on the next edge all outputs are at reset values and the state is IDLE.
- Hold out_ready=1 over more than 65535 accepts (force the counter near its limit) -> fetch_count stops at 0xFFFF.
